// File: rtl/spmv_fp16_row_acc.sv
// Per-row FP16 accumulator: IDLE -> ALIGN -> ADD -> NORM per product, OUT holds the row sum.
// One product per 4 cycles; results held on o_* until o_ready.
module spmv_fp16_row_acc #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [15:0]      i_prod,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [15:0]      o_result,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  state_t            r_state, w_next;
  logic [15:0]       r_a, r_b;
  logic              r_last, r_ovf, r_sign, r_sub, r_inf;
  logic [CNT_W-1:0]  r_cnt;
  logic [13:0]       r_big_m, r_sml_m;
  logic [4:0]        r_exp;
  logic [14:0]       r_sum;

  function automatic logic [3:0] f_lzc(input logic [13:0] v);
    f_lzc = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) f_lzc = 4'(13 - i);
    end
  endfunction

  // Exponent 0 (zero or subnormal) compares and adds as +0.
  logic        w_a_zero, w_b_zero, w_swap, w_big_zero, w_sml_zero;
  logic [14:0] w_a_key, w_b_key;
  logic [15:0] w_big, w_sml;
  logic [13:0] w_big_m, w_sml_m;
  logic [4:0]  w_diff;

  always_comb begin
    w_a_zero   = (r_a[14:10] == 5'd0);
    w_b_zero   = (r_b[14:10] == 5'd0);
    w_a_key    = w_a_zero ? 15'd0 : r_a[14:0];
    w_b_key    = w_b_zero ? 15'd0 : r_b[14:0];
    w_swap     = (w_b_key > w_a_key);
    w_big      = w_swap ? r_b : r_a;
    w_sml      = w_swap ? r_a : r_b;
    w_big_zero = w_swap ? w_b_zero : w_a_zero;
    w_sml_zero = w_swap ? w_a_zero : w_b_zero;
    w_big_m    = w_big_zero ? 14'd0 : {1'b1, w_big[9:0], 3'b000};
    w_sml_m    = w_sml_zero ? 14'd0 : {1'b1, w_sml[9:0], 3'b000};
    w_diff     = w_big[14:10] - w_sml[14:10];
  end

  logic               w_carry, w_ovf_now;
  logic [3:0]         w_lzc;
  logic [13:0]        w_shl;
  logic [10:0]        w_mn;
  logic signed [6:0]  w_exp_n;
  logic [15:0]        w_res;

  always_comb begin
    w_carry   = r_sum[14];
    w_lzc     = f_lzc(r_sum[13:0]);
    w_shl     = r_sum[13:0] << w_lzc;
    w_mn      = w_carry ? r_sum[14:4] : 11'(w_shl >> 3);
    w_exp_n   = $signed(7'(r_exp) + 7'(w_carry) - 7'(w_lzc));
    w_ovf_now = 1'b0;
    w_res     = {r_sign, w_exp_n[4:0], w_mn[9:0]};
    if (r_inf) begin
      w_ovf_now = 1'b1;
    end else if (!w_mn[10]) begin
      w_res = 16'h0000;
    end else if (w_exp_n >= 7'sd31) begin
      w_ovf_now = 1'b1;
    end else if (w_exp_n <= 7'sd0) begin
      w_res = 16'h0000;
    end
    if (w_ovf_now) w_res = {r_sign, 15'h7BFF};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    i_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) w_next = S_ALIGN;
      end
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = r_last ? S_OUT : S_IDLE;
      S_OUT: begin
        o_valid = 1'b1;
        if (o_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_big_m <= 14'd0;
      r_sml_m <= 14'd0;
      r_exp   <= 5'd0;
      r_sign  <= 1'b0;
      r_sub   <= 1'b0;
      r_inf   <= 1'b0;
      r_sum   <= 15'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_b    <= i_prod;
            r_last <= i_last;
          end
        end
        S_ALIGN: begin
          r_big_m <= w_big_m;
          r_sml_m <= (w_diff >= 5'd14) ? 14'd0 : (w_sml_m >> w_diff);
          r_exp   <= w_big_zero ? 5'd0 : w_big[14:10];
          r_sign  <= w_big[15];
          r_sub   <= w_big[15] ^ w_sml[15];
          r_inf   <= (r_b[14:10] == 5'h1F);
        end
        S_ADD: begin
          r_sum <= r_sub ? ({1'b0, r_big_m} - {1'b0, r_sml_m})
                         : ({1'b0, r_big_m} + {1'b0, r_sml_m});
        end
        S_NORM: begin
          r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          // Once saturated, the row sum is frozen; only the count advances.
          if (!r_ovf) begin
            r_a   <= w_res;
            r_ovf <= w_ovf_now;
          end
        end
        S_OUT: begin
          if (o_ready) begin
            r_a   <= 16'h0000;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_a;
  assign o_cnt    = r_cnt;
  assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_spmv_fp16_row_acc.sv
// Bench for spmv_fp16_row_acc: row table plus backpressure and mid-row reset sequences.
module tb_spmv_fp16_row_acc;
  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready;
  logic [15:0]      i_prod = 16'h0000;
  logic             i_last = 1'b0;
  logic             o_valid;
  logic             o_ready = 1'b1;
  logic [15:0]      o_result;
  logic [CNT_W-1:0] o_cnt;
  logic             o_ovf;

  spmv_fp16_row_acc #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_ready(i_ready),
    .i_prod(i_prod), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready),
    .o_result(o_result), .o_cnt(o_cnt), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [2:0][15:0] p;
    logic [3:0]       n;
    logic [15:0]      res;
    logic [15:0]      cnt;
    logic             ovf;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   last_hc = 0;
  logic prev_vld = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Scoreboard: compare on the cycle the result beat is accepted.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_valid && !prev_vld) check("latency", cyc - last_hc, 4);
    prev_vld = o_valid;
    if (o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL stale_out: got result %h with empty queue", o_result);
      end else begin
        e = exp_q.pop_front();
        check("result", o_result, e.res);
        check("cnt", o_cnt, e.cnt);
        check("ovf", o_ovf, e.ovf);
      end
    end
  end

  task automatic send(input logic [15:0] p, input logic l, input exp_t e, output int hc);
    int b;
    b = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_prod  = p;
    i_last  = l;
    while (!i_ready && b < 100) begin
      @(negedge i_clk);
      b++;
    end
    if (!i_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: i_ready %b want 1", i_ready);
      hc = 0;
    end else begin
      hc      = cyc;
      last_hc = cyc;
      if (l) exp_q.push_back(e);
      @(posedge i_clk);
    end
  endtask

  task automatic run_row(input vec_t v);
    int   hc[3];
    exp_t e;
    e.res = v.res;
    e.cnt = v.cnt;
    e.ovf = v.ovf;
    for (int k = 0; k < int'(v.n); k++) send(v.p[k], (k == int'(v.n) - 1), e, hc[k]);
    for (int k = 1; k < int'(v.n); k++) check("spacing", hc[k] - hc[k-1], 4);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge i_clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending want 0", exp_q.size());
    end
    @(negedge i_clk);
  endtask

  function automatic vec_t mk(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                              input logic [3:0] n, input logic [15:0] res, input logic [15:0] cnt,
                              input logic ovf);
    vec_t v;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2;
    v.n = n; v.res = res; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    int   hc;
    int   b;
    exp_t e;
    vec_t v;

    tbl[0]  = mk(16'h3C00, 16'h0000, 16'h0000, 4'd1, 16'h3C00, 16'd1, 1'b0);
    tbl[1]  = mk(16'h3C00, 16'h4000, 16'h3800, 4'd3, 16'h4300, 16'd3, 1'b0);
    tbl[2]  = mk(16'h6400, 16'h3C00, 16'h0000, 4'd2, 16'h6401, 16'd2, 1'b0);
    tbl[3]  = mk(16'h6400, 16'h3800, 16'h0000, 4'd2, 16'h6400, 16'd2, 1'b0);
    tbl[4]  = mk(16'h0000, 16'h0000, 16'h0000, 4'd2, 16'h0000, 16'd2, 1'b0);
    tbl[5]  = mk(16'h3C00, 16'hBC00, 16'h0000, 4'd2, 16'h0000, 16'd2, 1'b0);
    tbl[6]  = mk(16'h7BFF, 16'h7BFF, 16'h0000, 4'd2, 16'h7BFF, 16'd2, 1'b1);
    tbl[7]  = mk(16'h4000, 16'h0000, 16'h0000, 4'd1, 16'h4000, 16'd1, 1'b0);
    tbl[8]  = mk(16'h0000, 16'h0000, 16'h0000, 4'd1, 16'h0000, 16'd1, 1'b0);
    tbl[9]  = mk(16'h7C00, 16'h3C00, 16'h0000, 4'd2, 16'h7BFF, 16'd2, 1'b1);
    tbl[10] = mk(16'hC000, 16'h3C00, 16'h0000, 4'd2, 16'hBC00, 16'd2, 1'b0);
    tbl[11] = mk(16'h0600, 16'h8400, 16'h0000, 4'd2, 16'h0000, 16'd2, 1'b0);
    tbl[12] = mk(16'h0001, 16'h3C00, 16'h0000, 4'd2, 16'h3C00, 16'd2, 1'b0);

    repeat (3) @(negedge i_clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_result", o_result, 16'h0000);
    check("rst_o_cnt", o_cnt, 0);
    check("rst_o_ovf", o_ovf, 0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("rst_i_ready", i_ready, 1);

    for (int i = 0; i < 13; i++) begin
      run_row(tbl[i]);
      drain();
    end

    // Backpressure: result must hold and input stay blocked.
    @(posedge i_clk);
    #1 o_ready = 1'b0;
    run_row(mk(16'h4000, 16'h0000, 16'h0000, 4'd1, 16'h4000, 16'd1, 1'b0));
    b = 0;
    while (!o_valid && b < 20) begin
      @(negedge i_clk);
      b++;
    end
    check("bp_valid", o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("bp_hold_result", o_result, 16'h4000);
      check("bp_hold_irdy", i_ready, 0);
    end
    @(posedge i_clk);
    #1 o_ready = 1'b1;
    drain();
    run_row(mk(16'h3800, 16'h0000, 16'h0000, 4'd1, 16'h3800, 16'd1, 1'b0));
    drain();

    // Reset mid-row discards the partial sum.
    e = '0;
    send(16'h4000, 1'b0, e, hc);
    send(16'h4000, 1'b0, e, hc);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b0;
    @(negedge i_clk);
    check("midrst_cnt", o_cnt, 0);
    check("midrst_result", o_result, 16'h0000);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("midrst_i_ready", i_ready, 1);
    v = mk(16'h3C00, 16'h0000, 16'h0000, 4'd1, 16'h3C00, 16'd1, 1'b0);
    run_row(v);
    drain();
    repeat (10) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/spmv_fp16_row_acc.md
# spmv_fp16_row_acc

Row accumulator at the output end of the SpMV FP16 datapath. Consumes the stream of FP16 products from the per-element multiplier, sums them per matrix row with a multi-cycle FP16 adder, and emits one FP16 row result per row-end marker. Input and output both use valid/ready handshakes. The output is held until the downstream result writer accepts it.

## Interface
- CNT_W, 16, width of per-row element counter
- i_clk  input  1  clock
- i_rstn  input  1  reset; asynchronous, active-low
- i_valid  input  1  product word valid
- i_ready  output  1  accumulator can accept a product
- i_prod  input  16  FP16 product: sign[15], exp[14:10], mant[9:0]
- i_last  input  1  product is the last of its row
- o_valid  output  1  row result valid
- o_ready  input  1  downstream accepts row result
- o_result  output  16  FP16 row sum
- o_cnt  output  CNT_W  products accumulated in this row; saturates at all-ones
- o_ovf  output  1  row saturated (overflow or exp==31 input)

## Operation
- FSM states:
  - IDLE: i_ready=1. On i_valid&i_ready, capture i_prod/i_last into B and go to ALIGN.
  - ALIGN: swap so |A|≥|B| by {exp,mant}, where A is the accumulator. Form 14-bit mantissas {1,mant,3'b000}. Right-shift the smaller by the exponent difference; a difference ≥14 gives 0.
  - ADD: same signs add, otherwise larger minus smaller. Result sign is the sign of the larger operand.
  - NORM: on carry, shift right 1 and exp+1. Otherwise shift left by leading-zero count and reduce exp. Truncate the 3 guard bits (round toward zero). Write A, increment cnt. Go to OUT if the captured last is set, else IDLE.
  - OUT: o_valid=1, o_result=A. On o_ready, clear A/cnt/ovf to 0 and go to IDLE.
- Zero handling: any operand with exp==0 (zero or subnormal) is treated as +0. The add yields the other operand unchanged.
- Subnormal results:
  - A normalized exp ≤0 flushes to 0x0000.
  - Exact cancellation gives 0x0000 (+0).
- Saturation:
  - Result exp ≥31, or input exp==31, sets ovf. A becomes 0x7BFF or 0xFBFF, using the sign of the larger operand.
  - Once ovf is set, later products in the row still increment cnt, but A stays saturated.
- A zero product still takes the full ALIGN/ADD/NORM path, so timing is uniform.
- Empty rows: the feeder sends 0x0000 with i_last. The result is 0x0000 with o_cnt=1.
- i_ready=0 in ALIGN/ADD/NORM/OUT. i_prod is ignored whenever i_ready=0.

## Timing
- Reset values:
  - State IDLE; A=0x0000; cnt=0; ovf=0.
  - o_valid=0, o_result=0x0000, o_cnt=0, o_ovf=0.
  - i_ready=1 from the first cycle after i_rstn deasserts.
- Reset mid-row or mid-OUT discards the partial row and any pending result. No output is produced for it.
- Handshake at edge t0: ALIGN in t0–t1, ADD in t1–t2, NORM in t2–t3. A is updated at edge t3.
- i_ready returns high after t3, giving a next acceptance no earlier than t4. Sustained throughput is 1 product per 4 cycles.
- Last product accepted at edge t0: o_valid is high in the cycle after edge t3, i.e. 3 cycles of latency.
- o_result, o_cnt and o_ovf are stable while o_valid=1 and o_ready=0.
- When o_valid&o_ready at edge t: o_valid is 0 and i_ready is 1 after t. There are no back-to-back result beats.
- o_ready is ignored when o_valid=0.

## Test plan
- Single product 0x3C00 with i_last: o_result=0x3C00, o_cnt=1, o_ovf=0. o_valid rises 3 cycles after the handshake edge.
- Row 0x3C00, 0x4000, 0x3800 (last): o_result=0x4300 (3.5), o_cnt=3. Handshakes are spaced exactly 4 cycles apart with i_valid held high.
- Alignment:
  - Row 0x6400, 0x3C00 gives 0x6401.
  - Row 0x6400, 0x3800 gives 0x6400 (truncated).
  - Row 0x0000, 0x0000 (last) gives 0x0000, o_cnt=2.
- Cancellation: 0x3C00, 0xBC00 gives 0x0000. Overflow: 0x7BFF, 0x7BFF gives 0x7BFF with o_ovf=1. The following row 0x4000 (last) gives 0x4000 with o_ovf=0.
- Backpressure: hold o_ready=0 for 5 cycles with o_valid high. o_result stays constant and i_ready stays 0. The next row is accepted only after the o_ready handshake.
- Reset mid-row: accept 0x4000 and 0x4000, then pulse i_rstn low. Then send 0x3C00 (last): o_result=0x3C00, o_cnt=1, and no stale result appears.
